operand_pack: RTL

// - Upstream feeder of the 32-bit adder stage. Collects the UART RX byte stream into two

---
 rtl/uart_alu_pkg.sv | 17 +
 rtl/idle_timer.sv | 33 +++
 rtl/operand_pack.sv | 127 ++++++++++++
 3 files changed

// File: rtl/uart_alu_pkg.sv
// Shared constants and types for the UART-fed adder datapath.
package uart_alu_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        COLLECT_A = 2'd0,
        COLLECT_B = 2'd1,
        HOLD      = 2'd2
    } pack_state_e;

    // Width of a counter that indexes n items; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/idle_timer.sv
// Mid-frame idle watchdog: counts enabled, non-cleared cycles and flags the
// cycle on which the count reaches TIMEOUT_CYCLES_P-1.
module idle_timer #(
    parameter int TIMEOUT_CYCLES_P = 1000
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYCLES_P + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES_P - 1);

    logic [CW-1:0] count_q;

    // A clear in the same cycle masks expiry, so a late byte always wins.
    assign expire = enable & ~clear & (count_q == LAST);

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q <= '0;
        end else if (clear || expire) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/operand_pack.sv
// Packs the RX byte stream into little-endian operand pairs for the adder.
// Optional mid-frame timeout enabled by defining OPERAND_PACK_TIMEOUT_EN.
module operand_pack
    import uart_alu_pkg::*;
#(
    parameter int WIDTH_P          = 32,
    parameter int TIMEOUT_CYCLES_P = 1000
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               byte_valid_i,
    input  logic [BYTE_W-1:0]  byte_i,
    output logic               byte_ready_o,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [WIDTH_P-1:0] operand_a_o,
    output logic [WIDTH_P-1:0] operand_b_o,
    output logic               frame_drop_o
);

    localparam int N     = WIDTH_P / BYTE_W;
    localparam int CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if (WIDTH_P < BYTE_W || (WIDTH_P % BYTE_W) != 0) begin : g_bad_width
        $error("operand_pack: WIDTH_P must be a positive multiple of 8");
    end
    if (TIMEOUT_CYCLES_P < 2) begin : g_bad_timeout
        $error("operand_pack: TIMEOUT_CYCLES_P must be at least 2");
    end

    pack_state_e        state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH_P-1:0] a_q, b_q;
    logic               drop_q, drop_d;
    logic               accept;
    logic               last_byte;
    logic               expire;

    assign byte_ready_o = (state_q != HOLD);
    assign valid_o      = (state_q == HOLD);
    assign accept       = byte_valid_i & byte_ready_o;
    assign last_byte    = (count_q == LAST);
    assign operand_a_o  = a_q;
    assign operand_b_o  = b_q;
    assign frame_drop_o = drop_q;

`ifdef OPERAND_PACK_TIMEOUT_EN
    idle_timer #(
        .TIMEOUT_CYCLES_P(TIMEOUT_CYCLES_P)
    ) u_idle_timer (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .clear   (accept | (state_q == COLLECT_A && count_q == '0)),
        .enable  (state_q != HOLD),
        .expire  (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        drop_d  = 1'b0;
        unique case (state_q)
            COLLECT_A, COLLECT_B: begin
                if (accept) begin
                    if (last_byte) begin
                        state_d = (state_q == COLLECT_A) ? COLLECT_B : HOLD;
                        count_d = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else if (expire) begin
                    state_d = COLLECT_A;
                    count_d = '0;
                    drop_d  = 1'b1;
                end
            end
            HOLD: begin
                if (ready_i) begin
                    state_d = COLLECT_A;
                    count_d = '0;
                end
            end
            default: begin
                state_d = COLLECT_A;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= COLLECT_A;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // NOTE: the operand registers are reset on purpose: downstream sees
    // defined zeros after reset rather than stale partial-frame bytes.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            a_q <= '0;
            b_q <= '0;
        end else if (accept) begin
            for (int k = 0; k < N; k++) begin
                if (count_q == CNT_W'(k)) begin
                    if (state_q == COLLECT_A) begin
                        a_q[k*BYTE_W +: BYTE_W] <= byte_i;
                    end else begin
                        b_q[k*BYTE_W +: BYTE_W] <= byte_i;
                    end
                end
            end
        end
    end

endmodule
